// File: rtl/mmu_loader.sv
// Context-switch engine: streams up to four translation tables from memory into
// the MMU register port, then restores the MMU fault/address register.
module mmu_loader #(
   parameter int RV   = 16,
   parameter int PA   = RV,
   parameter int NMMU = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [3:0]            tbl_mask,
   input  logic [PA-RV/16-1:0]   tbl_base,
   output logic                  busy,
   output logic                  done,
   output logic                  mem_req,
   output logic [PA-RV/16-1:0]   mem_addr,
   input  logic                  mem_ack,
   input  logic [RV-1:0]         mem_rdata,
   input  logic [RV-1:0]         mmu_reg_read,
   output logic                  mmu_reg_write,
   output logic [RV-1:0]         mmu_reg_data
);

   localparam int LG = $clog2(NMMU);
   localparam int AW = PA - RV/16;
   localparam logic [LG-1:0] LAST_ENTRY = LG'(NMMU - 1);
   localparam logic [AW-1:0] LOW_MASK   = AW'((1 << (LG + 2)) - 1);

   typedef enum logic [2:0] {IDLE, SETUP, FETCH, WRITE, RESTORE, DONE} state_t;

   state_t          state;
   logic [RV-1:0]   saved;
   logic [3:0]      mask;
   logic [AW-1:0]   base;
   logic [1:0]      tbl;
   logic [LG-1:0]   entry;
   logic [3:0]      remaining;

   assign remaining = mask & ~(4'b0001 << tbl);

   function automatic logic [1:0] top_bit(input logic [3:0] m);
      if (m[3])      return 2'd3;
      else if (m[2]) return 2'd2;
      else if (m[1]) return 2'd1;
      else if (m[0]) return 2'd0;
      else           return 2'd0;
   endfunction

   // Setup word selects the table: bit3=ins (tbl[0]), bit2=sup (tbl[1]), entry field 0.
   function automatic logic [RV-1:0] setup_word(input logic [1:0] t);
      logic [RV-1:0] w;
      w    = '0;
      w[3] = t[0];
      w[2] = t[1];
      return w;
   endfunction

   // Address is a field substitution into the aligned base, never an add.
   function automatic logic [AW-1:0] table_addr(input logic [AW-1:0] b,
                                                input logic [1:0] t,
                                                input logic [LG-1:0] e);
      return (b & ~LOW_MASK) | AW'({t, e});
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         busy          <= 1'b0;
         done          <= 1'b0;
         mem_req       <= 1'b0;
         mem_addr      <= '0;
         mmu_reg_write <= 1'b0;
         mmu_reg_data  <= '0;
         saved         <= '0;
         mask          <= '0;
         base          <= '0;
         tbl           <= '0;
         entry         <= '0;
      end else begin
         done          <= 1'b0;
         mmu_reg_write <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  saved <= mmu_reg_read;
                  mask  <= tbl_mask;
                  base  <= tbl_base;
                  busy  <= 1'b1;
                  if (tbl_mask == 4'b0000) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     tbl           <= top_bit(tbl_mask);
                     mmu_reg_write <= 1'b1;
                     mmu_reg_data  <= setup_word(top_bit(tbl_mask));
                     state         <= SETUP;
                  end
               end
            end
            SETUP: begin
               entry    <= '0;
               mem_req  <= 1'b1;
               mem_addr <= table_addr(base, tbl, '0);
               state    <= FETCH;
            end
            FETCH: begin
               if (mem_ack) begin
                  mem_req       <= 1'b0;
                  mmu_reg_write <= 1'b1;
                  mmu_reg_data  <= mem_rdata | RV'(1);
                  state         <= WRITE;
               end
            end
            WRITE: begin
               if (entry != LAST_ENTRY) begin
                  entry    <= entry + 1'b1;
                  mem_req  <= 1'b1;
                  mem_addr <= table_addr(base, tbl, entry + 1'b1);
                  state    <= FETCH;
               end else begin
                  mask          <= remaining;
                  mmu_reg_write <= 1'b1;
                  if (remaining != 4'b0000) begin
                     tbl          <= top_bit(remaining);
                     mmu_reg_data <= setup_word(top_bit(remaining));
                     state        <= SETUP;
                  end else begin
                     mmu_reg_data <= saved & ~RV'(1);
                     state        <= RESTORE;
                  end
               end
            end
            RESTORE: begin
               done  <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy    <= 1'b0;
               mem_req <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule
